// File: rtl/veto_err_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : veto_err_pkg
//  Description : Shared types and constants for the multi-channel veto error
//                capture: per-channel FSM state encoding, default frame
//                geometry and a clog2-based width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package veto_err_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } chan_state_e;

  localparam int         DEF_LENGTH_ERR  = 232;
  localparam int         DEF_HDR_LEN     = 3;
  localparam logic [2:0] DEF_HDR_PATTERN = 3'b101;
  localparam int         DEF_TIMEOUT     = 4095;

  // Width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2w(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/veto_err_chan.sv
`default_nettype none
// ============================================================================
//  Module      : veto_err_chan
//  Description : One serial veto error channel. Hunts for the header in the
//                incoming bit stream, then deserialises LENGTH_ERR payload bits
//                (bit 0 first) and counts the ones. Falls back to a timed-out
//                DONE state when the shared timeout fires while still hunting.
//  Ports       : clk, rst_n (async, active low), in_live (low = clear/re-arm),
//                in_err (serial bit), tmo_hit (shared timeout reached),
//                got_veto_err, timeout, payload, err_cnt
//  Revision    : 1.0  initial release
// ============================================================================
module veto_err_chan
  import veto_err_pkg::*;
#(
  parameter int                 LENGTH_ERR  = DEF_LENGTH_ERR,
  parameter int                 HDR_LEN     = DEF_HDR_LEN,
  parameter logic [HDR_LEN-1:0] HDR_PATTERN = DEF_HDR_PATTERN,
  parameter int                 CW          = clog2w(LENGTH_ERR + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_live,
  input  logic                  in_err,
  input  logic                  tmo_hit,
  output logic                  got_veto_err,
  output logic                  timeout,
  output logic [LENGTH_ERR-1:0] payload,
  output logic [CW-1:0]         err_cnt
);

  localparam logic [3:0]    FILL_FULL = 4'(HDR_LEN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LENGTH_ERR);

  chan_state_e           state_q, state_d;
  logic [HDR_LEN-1:0]    hdr_q, hdr_d;
  logic [3:0]            fill_q, fill_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         err_cnt_q, err_cnt_d;
  logic [LENGTH_ERR-1:0] payload_q, payload_d;
  logic                  got_q, got_d;
  logic                  tmo_q, tmo_d;
  logic                  hdr_match;

  // The fill check stops an all-zero power-up register from matching a
  // pattern that has leading zeros before enough bits have arrived.
  assign hdr_match = (hdr_q == HDR_PATTERN) && (fill_q == FILL_FULL);

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    payload_d = payload_q;
    got_d     = got_q;
    tmo_d     = tmo_q;
    if (!in_live) begin
      state_d   = ST_HUNT;
      hdr_d     = '0;
      fill_d    = '0;
      cnt_d     = '0;
      err_cnt_d = '0;
      payload_d = '0;
      got_d     = 1'b0;
      tmo_d     = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (hdr_match) begin
            // The bit arriving alongside the match is already payload bit 0.
            // Match takes priority over a coincident timeout.
            state_d      = ST_CAPTURE;
            payload_d[0] = in_err;
            cnt_d        = CW'(1);
            err_cnt_d    = CW'(in_err);
          end else if (tmo_hit) begin
            state_d = ST_DONE;
            got_d   = 1'b1;
            tmo_d   = 1'b1;
          end else begin
            hdr_d = {hdr_q[HDR_LEN-2:0], in_err};
            if (fill_q != FILL_FULL) begin
              fill_d = fill_q + 4'd1;
            end
          end
        end
        ST_CAPTURE: begin
          // Completion is flagged one edge after the last bit is written.
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            got_d   = 1'b1;
          end else begin
            payload_d[cnt_q] = in_err;
            cnt_d            = cnt_q + CW'(1);
            err_cnt_d        = err_cnt_q + CW'(in_err);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      hdr_q     <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      payload_q <= '0;
      got_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      payload_q <= payload_d;
      got_q     <= got_d;
      tmo_q     <= tmo_d;
    end
  end

  assign got_veto_err = got_q;
  assign timeout      = tmo_q;
  assign payload      = payload_q;
  assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire

// File: rtl/veto_err_capture.sv
`default_nettype none
// ============================================================================
//  Module      : veto_err_capture
//  Description : NCH-channel veto error capture. Instantiates one header
//                hunter / deserialiser per channel, owns the shared header
//                timeout counter and the registered all-channels-done flag.
//  Ports       : clk, rst_n (async, active low), in_live (capture enable),
//                in_err[NCH] serial inputs, got_veto_err[NCH], all_got,
//                timeout[NCH], out_veto_err_bus[NCH*LENGTH_ERR],
//                err_cnt_bus[NCH*CW]
//  Revision    : 1.0  initial release
// ============================================================================
module veto_err_capture
  import veto_err_pkg::*;
#(
  parameter int                 NCH         = 4,
  parameter int                 LENGTH_ERR  = DEF_LENGTH_ERR,
  parameter int                 HDR_LEN     = DEF_HDR_LEN,
  parameter logic [HDR_LEN-1:0] HDR_PATTERN = DEF_HDR_PATTERN,
  parameter int                 TIMEOUT     = DEF_TIMEOUT,
  localparam int                CW          = clog2w(LENGTH_ERR + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_live,
  input  logic [NCH-1:0]            in_err,
  output logic [NCH-1:0]            got_veto_err,
  output logic                      all_got,
  output logic [NCH-1:0]            timeout,
  output logic [NCH*LENGTH_ERR-1:0] out_veto_err_bus,
  output logic [NCH*CW-1:0]         err_cnt_bus
);

  localparam int            TW        = clog2w(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          all_got_q, all_got_d;
  logic          tmo_hit;

  // Counts live cycles and parks at TIMEOUT; a zero TIMEOUT never fires.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    all_got_d = in_live & (&got_veto_err);
    if (!in_live) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_LIMIT) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      all_got_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      all_got_q <= all_got_d;
    end
  end

  assign all_got = all_got_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    veto_err_chan #(
      .LENGTH_ERR  (LENGTH_ERR),
      .HDR_LEN     (HDR_LEN),
      .HDR_PATTERN (HDR_PATTERN),
      .CW          (CW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_live      (in_live),
      .in_err       (in_err[c]),
      .tmo_hit      (tmo_hit),
      .got_veto_err (got_veto_err[c]),
      .timeout      (timeout[c]),
      .payload      (out_veto_err_bus[c*LENGTH_ERR +: LENGTH_ERR]),
      .err_cnt      (err_cnt_bus[c*CW +: CW])
    );
  end

endmodule
`default_nettype wire

// File: doc/veto_err_capture.md
# veto_err_capture

Multi-channel, parametrised successor to the single-stream veto error capture in the fanout CDT. Each of `NCH` serial error lines from the veto front-ends is hunted for a configurable header, then `LENGTH_ERR` payload bits are deserialised into a per-channel bus, with a running count of set bits. Channels that never produce a header within a timeout window are flagged instead of hanging the readout. Sits between the veto error inputs and the CDT error-reporting / readout logic; gated by the run `in_live` level.

## Interface
Parameters:
- `NCH`, 4, number of serial error channels (1..16)
- `LENGTH_ERR`, 232, payload bits per channel, header excluded (1..255)
- `HDR_LEN`, 3, header length in bits (2..8)
- `HDR_PATTERN`, 3'b101, header value; LSB is the most recently received bit
- `TIMEOUT`, 4095, cycles after live-start allowed for header detection; 0 disables timeout
- `CW`, derived = clog2(`LENGTH_ERR`+1), error-count width

Ports:
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous, active-low reset
- `in_live` in 1 capture enable; low = synchronous clear/re-arm
- `in_err` in `NCH` serial error bits, one per channel, sampled each `clk`
- `got_veto_err` out `NCH` per-channel frame complete (sticky while live)
- `all_got` out 1 all channels complete
- `timeout` out `NCH` per-channel header timeout (sticky while live)
- `out_veto_err_bus` out `NCH*LENGTH_ERR` captured payloads; channel c at [c*LENGTH_ERR +: LENGTH_ERR]
- `err_cnt_bus` out `NCH*CW` number of 1s in each channel's payload; channel c at [c*CW +: CW]

## Operation
- Reset (`rst_n`=0, async) and `in_live`=0 (sync) both force: all outputs 0, every channel to HUNT, header shift register and fill counter 0, bit counter 0, timeout counter 0.
- Per-channel FSM, states HUNT, CAPTURE, DONE:
  - HUNT: shift `in_err[c]` into `HDR_LEN`-bit register (new bit at LSB); fill counter saturates at `HDR_LEN`. Header match = register == `HDR_PATTERN` AND fill == `HDR_LEN`, evaluated on register contents before this cycle's shift. Match -> CAPTURE, and the current cycle's `in_err[c]` is payload bit 0 (written, counted).
  - CAPTURE: write `in_err[c]` to bit index `cnt`, `cnt`+1, `err_cnt` += bit. When `cnt` reaches `LENGTH_ERR` -> DONE.
  - DONE: `got_veto_err[c]`=1; payload and count frozen; further input ignored until `in_live` low.
- Timeout: shared counter increments each live cycle, saturating at `TIMEOUT`. When it equals `TIMEOUT` (non-zero) any channel still in HUNT -> DONE with `timeout[c]`=1, `got_veto_err[c]`=1, payload and count 0. Channels in CAPTURE are never timed out.
- `all_got` = AND of `got_veto_err`, registered.
- Payload bits keep arrival order: bit 0 first.

## Timing
- Header bits sampled on edges k..k+`HDR_LEN`-1; match visible at edge k+`HDR_LEN`, which samples payload bit 0.
- Last payload bit sampled at edge k+`HDR_LEN`+`LENGTH_ERR`-1; `got_veto_err[c]` high after the following edge (one-cycle latency, as existing downstream expects). `all_got` one edge after the last `got_veto_err`.
- Timeout: with `in_live` rising before edge 0, `timeout`/`got` rise after edge `TIMEOUT`.
- Header match and timeout on the same edge: match wins (channel enters CAPTURE).
- `in_live` dropping mid-capture: partial data discarded, all outputs 0 next edge; next live period restarts header hunt with empty register.
- Header pattern bits in payload are not re-detected (no re-hunt in CAPTURE/DONE).

## Structure
- Package `veto_err_pkg`: FSM state enum (HUNT, CAPTURE, DONE), clog2-based width function, default `LENGTH_ERR`/`HDR_PATTERN` constants.
- Sub-module `veto_err_chan`: one channel's header shifter, FSM, payload register, bit and error counters; inputs `clk`, `rst_n`, `in_live`, `in_err`, `tmo_hit`. Top instantiates `NCH` copies via generate, owns timeout counter and `all_got`.

## Test plan
- NCH=4, all channels send 101 then 232-bit alternating 1/0 -> each bus = alternating with bit0=1, `err_cnt`=116, `got` one cycle after last bit, `all_got` one cycle later, `timeout`=0.
- Channels offset by 0/7/50/200 cycles, random payloads -> per-channel payload matches scoreboard, `got` rises per channel independently.
- Channel 2 stays 0, TIMEOUT=100 -> after edge 100 `timeout`=4'b0100, `got[2]`=1, bus 0, `all_got`=1 once others finish.
- Leading 0s then 0101: match only after fill; stream starting 01 with empty register does not false-match; payload containing 101 captured as data.
- `in_live` low at payload bit 120 then high, fresh frame -> outputs clear next edge, second frame captured correctly; `rst_n` asserted mid-capture -> outputs 0 immediately, no clock needed.
